// File: rtl/fma_pkg.sv
// fma_pkg: shared definitions for the F32 FMA issue sequencer.
//   FN_*        decode function codes presented on req_fn
//   RM_DYN      instruction rm value selecting the CSR rounding mode
//   REC_ONE_F32 recoded +1.0, used as the multiplicand for FADD/FSUB
//   fma_result_t one FMA result as returned by the pipe {data, flags}
package fma_pkg;

  localparam int unsigned REC_W  = 33;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned FN_W   = 3;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [FN_W-1:0] {
    FN_FMADD  = 3'd0,
    FN_FMSUB  = 3'd1,
    FN_FNMSUB = 3'd2,
    FN_FNMADD = 3'd3,
    FN_FADD   = 3'd4,
    FN_FSUB   = 3'd5,
    FN_FMUL   = 3'd6,
    FN_RSVD   = 3'd7
  } fma_fn_e;

  localparam logic [RM_W-1:0]  RM_DYN      = 3'd7;
  localparam logic [REC_W-1:0] REC_ONE_F32 = 33'h080000000;

  typedef struct packed {
    logic [REC_W-1:0]  data;
    logic [FLAG_W-1:0] flags;
  } fma_result_t;

endpackage

// File: rtl/fma_issue_seq_if.sv
// fma_issue_seq_if: request and response channels of the FMA issue sequencer.
//   req_*  : decode -> sequencer, valid/ready, operands and destination tag
//   resp_* : sequencer -> writeback, valid/ready, in-order results and flags
// master = decode/writeback side, slave = the sequencer.
interface fma_issue_seq_if #(
  parameter int unsigned TAG_W = 5
);
  import fma_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [FN_W-1:0]   req_fn;
  logic [RM_W-1:0]   req_rm;
  logic [TAG_W-1:0]  req_tag;
  logic [REC_W-1:0]  req_a;
  logic [REC_W-1:0]  req_b;
  logic [REC_W-1:0]  req_c;

  logic              resp_valid;
  logic              resp_ready;
  logic [TAG_W-1:0]  resp_tag;
  logic [REC_W-1:0]  resp_data;
  logic [FLAG_W-1:0] resp_flags;

  modport master (
    output req_valid, req_fn, req_rm, req_tag, req_a, req_b, req_c, resp_ready,
    input  req_ready, resp_valid, resp_tag, resp_data, resp_flags
  );

  modport slave (
    input  req_valid, req_fn, req_rm, req_tag, req_a, req_b, req_c, resp_ready,
    output req_ready, resp_valid, resp_tag, resp_data, resp_flags
  );

endinterface

// File: rtl/fma_result_fifo.sv
// fma_result_fifo: in-order result buffer with wrap-around pointers.
//   clock, reset : clock, synchronous active-high reset
//   wrEn, wrData : tail write (caller guarantees the FIFO is not full)
//   popEn        : head consume (caller qualifies with headValid)
//   headValid    : registered non-empty flag
//   headData     : head entry, read from the storage registers
module fma_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   wrEn,
  input  entry_t wrData,
  input  logic   popEn,
  output logic   headValid,
  output entry_t headData
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             notEmpty;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Occupancy; simultaneous write and pop leave it unchanged.
  always_comb begin
    countNext = count;
    case ({wrEn, popEn})
      2'b10:   countNext = count + CNT_W'(1);
      2'b01:   countNext = count - CNT_W'(1);
      default: countNext = count;
    endcase
  end

  // Pointer, count and head-valid registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      notEmpty <= 1'b0;
    end else begin
      if (wrEn)  wrPtr <= ptrInc(wrPtr);
      if (popEn) rdPtr <= ptrInc(rdPtr);
      count    <= countNext;
      notEmpty <= (countNext != '0);
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrPtr] <= wrData;
  end

  assign headValid = notEmpty;
  assign headData  = mem[rdPtr];

endmodule

// File: rtl/fma_issue_seq.sv
// fma_issue_seq: issue sequencer and result buffer for the pipelined F32 FMA.
//   clock, reset          : clock, synchronous active-high reset (shared with the FMA pipe)
//   bus (slave)           : req_* valid/ready request channel, resp_* in-order result channel
//   frm                   : CSR dynamic rounding mode
//   pipe_validin/op/a/b/c/rm : issue to the two-cycle no-stall FMA pipe (combinational)
//   pipe_out, pipe_flags  : FMA result, valid two cycles after issue
//   fflags_clr, fflags    : sticky exception flags accumulated at retire
module fma_issue_seq
  import fma_pkg::*;
#(
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TAG_W     = 5
) (
  input  logic              clock,
  input  logic              reset,
  fma_issue_seq_if.slave    bus,
  input  logic [RM_W-1:0]   frm,
  output logic              pipe_validin,
  output logic [OP_W-1:0]   pipe_op,
  output logic [REC_W-1:0]  pipe_a,
  output logic [REC_W-1:0]  pipe_b,
  output logic [REC_W-1:0]  pipe_c,
  output logic [RM_W-1:0]   pipe_rm,
  input  logic [REC_W-1:0]  pipe_out,
  input  logic [FLAG_W-1:0] pipe_flags,
  input  logic              fflags_clr,
  output logic [FLAG_W-1:0] fflags
);

  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RES_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    fma_result_t      res;
  } entry_t;

  logic             reqReady;
  logic             fire;
  logic             pop;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] usedNext;
  logic             stg0Valid;
  logic             stg1Valid;
  logic [TAG_W-1:0] stg0Tag;
  logic [TAG_W-1:0] stg1Tag;
  entry_t           wrEntry;
  entry_t           head;
  logic             headValid;

  assign fire          = bus.req_valid && reqReady;
  assign pop           = headValid && bus.resp_ready;
  assign bus.req_ready = reqReady;

  // Map decode functions onto the FMA datapath and resolve the rounding mode.
  always_comb begin
    pipe_validin = fire;
    pipe_op      = 2'd0;
    pipe_a       = bus.req_a;
    pipe_b       = bus.req_b;
    pipe_c       = bus.req_c;
    pipe_rm      = (bus.req_rm == RM_DYN) ? frm : bus.req_rm;
    case (bus.req_fn)
      FN_FMADD, FN_FMSUB, FN_FNMSUB, FN_FNMADD: begin
        pipe_op = bus.req_fn[1:0];
      end
      FN_FADD, FN_FSUB: begin
        // a*1.0 +/- b
        pipe_op = (bus.req_fn == FN_FSUB) ? 2'd1 : 2'd0;
        pipe_b  = REC_ONE_F32;
        pipe_c  = bus.req_b;
      end
      FN_FMUL: begin
        // Zero addend carries the product sign so exact-zero products keep it.
        pipe_c = {bus.req_a[REC_W-1] ^ bus.req_b[REC_W-1], (REC_W-1)'(0)};
      end
      default: begin
        pipe_op = 2'd0;
      end
    endcase
  end

  // Destination tags travel alongside the two pipe stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      stg0Valid <= 1'b0;
      stg1Valid <= 1'b0;
      stg0Tag   <= '0;
      stg1Tag   <= '0;
    end else begin
      stg0Valid <= fire;
      stg0Tag   <= bus.req_tag;
      stg1Valid <= stg0Valid;
      stg1Tag   <= stg0Tag;
    end
  end

  // Credit counter: every issued op already owns a FIFO slot.
  always_comb begin
    usedNext = used;
    case ({fire, pop})
      2'b10:   usedNext = used + CNT_W'(1);
      2'b01:   usedNext = used - CNT_W'(1);
      default: usedNext = used;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      used     <= '0;
      reqReady <= 1'b1;
    end else begin
      used     <= usedNext;
      reqReady <= (usedNext < DEPTH_CNT);
    end
  end

  assign wrEntry.tag       = stg1Tag;
  assign wrEntry.res.data  = pipe_out;
  assign wrEntry.res.flags = pipe_flags;

  fma_result_fifo #(
    .DEPTH   (RES_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wrEn      (stg1Valid),
    .wrData    (wrEntry),
    .popEn     (pop),
    .headValid (headValid),
    .headData  (head)
  );

  assign bus.resp_valid = headValid;
  assign bus.resp_tag   = head.tag;
  assign bus.resp_data  = head.res.data;
  assign bus.resp_flags = head.res.flags;

  // Sticky flags accumulate in retire order; a clear coinciding with a pop keeps the popped flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      fflags <= '0;
    end else if (pop) begin
      fflags <= (fflags_clr ? '0 : fflags) | head.res.flags;
    end else if (fflags_clr) begin
      fflags <= '0;
    end
  end

endmodule

// File: tb/tb_fma_issue_seq.sv
// tb_fma_issue_seq: directed vector bench for fma_issue_seq with a stub two-cycle FMA pipe.
module tb_fma_issue_seq;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  frm = 3'd0;
  logic        pipe_validin;
  logic [1:0]  pipe_op;
  logic [32:0] pipe_a, pipe_b, pipe_c;
  logic [2:0]  pipe_rm;
  logic [32:0] pipe_out;
  logic [4:0]  pipe_flags;
  logic        fflags_clr = 1'b0;
  logic [4:0]  fflags;

  // Stub pipe: result supplied by the bench at issue time, returned two cycles later.
  logic [32:0] stubOut = '0;
  logic [4:0]  stubFlags = '0;
  logic [32:0] p1d, p2d;
  logic [4:0]  p1f, p2f;

  int applied = 0;
  int errors = 0;
  int accepts;
  logic [4:0] expF;

  fma_issue_seq_if #(.TAG_W(5)) bus ();

  fma_issue_seq #(.RES_DEPTH(DEPTH), .TAG_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .frm          (frm),
    .pipe_validin (pipe_validin),
    .pipe_op      (pipe_op),
    .pipe_a       (pipe_a),
    .pipe_b       (pipe_b),
    .pipe_c       (pipe_c),
    .pipe_rm      (pipe_rm),
    .pipe_out     (pipe_out),
    .pipe_flags   (pipe_flags),
    .fflags_clr   (fflags_clr),
    .fflags       (fflags)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      p1d <= '0; p2d <= '0; p1f <= '0; p2f <= '0;
    end else begin
      p1d <= stubOut; p1f <= stubFlags;
      p2d <= p1d;     p2f <= p1f;
    end
  end
  assign pipe_out   = p2d;
  assign pipe_flags = p2f;

  typedef struct {
    logic [2:0]  fn, rm, frm;
    logic [4:0]  tag;
    logic [32:0] a, b, c, res;
    logic [4:0]  flg;
    logic [1:0]  eOp;
    logic [32:0] eA, eB, eC;
    logic [2:0]  eRm;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idleReq();
    bus.req_valid = 1'b0;
    bus.req_fn = 3'd0; bus.req_rm = 3'd0; bus.req_tag = 5'd0;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
  endtask

  task automatic driveOp(input logic [4:0] tag, input logic [32:0] res, input logic [4:0] flg);
    bus.req_valid = 1'b1; bus.req_fn = 3'd0; bus.req_rm = 3'd0; bus.req_tag = tag;
    bus.req_a = 33'h080000000; bus.req_b = 33'h080000000; bus.req_c = '0;
    stubOut = res; stubFlags = flg;
  endtask

  initial begin
    //          fn    rm    frm   tag    a             b             c             res           flg    op    eA            eB            eC            eRm
    vecs[0]  = '{3'd0, 3'd0, 3'd0, 5'd5,  33'h080800000, 33'h080C00000, 33'h080000000, 33'h081600000, 5'h00, 2'd0, 33'h080800000, 33'h080C00000, 33'h080000000, 3'd0};
    vecs[1]  = '{3'd4, 3'd7, 3'd3, 5'd6,  33'h080000000, 33'h071000000, 33'h012345678, 33'h080000001, 5'h01, 2'd0, 33'h080000000, 33'h080000000, 33'h071000000, 3'd3};
    vecs[2]  = '{3'd6, 3'd1, 3'd0, 5'd7,  33'h100000000, 33'h081200000, 33'h0AAAAAAAA, 33'h100000000, 5'h00, 2'd0, 33'h100000000, 33'h081200000, 33'h100000000, 3'd1};
    vecs[3]  = '{3'd6, 3'd4, 3'd0, 5'd8,  33'h0C0000000, 33'h000000000, 33'h155555555, 33'h0E0400000, 5'h10, 2'd0, 33'h0C0000000, 33'h000000000, 33'h000000000, 3'd4};
    vecs[4]  = '{3'd5, 3'd7, 3'd2, 5'd9,  33'h080800000, 33'h081000000, 33'h000000000, 33'h180800000, 5'h00, 2'd1, 33'h080800000, 33'h080000000, 33'h081000000, 3'd2};
    vecs[5]  = '{3'd1, 3'd2, 3'd0, 5'd10, 33'h080800000, 33'h080C00000, 33'h080000000, 33'h081200000, 5'h00, 2'd1, 33'h080800000, 33'h080C00000, 33'h080000000, 3'd2};
    vecs[6]  = '{3'd2, 3'd7, 3'd4, 5'd11, 33'h080800000, 33'h080C00000, 33'h080000000, 33'h181200000, 5'h00, 2'd2, 33'h080800000, 33'h080C00000, 33'h080000000, 3'd4};
    vecs[7]  = '{3'd3, 3'd5, 3'd0, 5'd12, 33'h080800000, 33'h080C00000, 33'h080000000, 33'h181600000, 5'h00, 2'd3, 33'h080800000, 33'h080C00000, 33'h080000000, 3'd5};
    vecs[8]  = '{3'd7, 3'd6, 3'd0, 5'd31, 33'h080800000, 33'h080C00000, 33'h080000000, 33'h081600000, 5'h00, 2'd0, 33'h080800000, 33'h080C00000, 33'h080000000, 3'd6};
    vecs[9]  = '{3'd6, 3'd0, 3'd0, 5'd13, 33'h181600000, 33'h180800000, 33'h0FFFFFFFF, 33'h081E00000, 5'h00, 2'd0, 33'h181600000, 33'h180800000, 33'h000000000, 3'd0};
    vecs[10] = '{3'd4, 3'd0, 3'd1, 5'd14, 33'h080800000, 33'h180000000, 33'h000000000, 33'h080000000, 5'h00, 2'd0, 33'h080800000, 33'h080000000, 33'h180000000, 3'd0};
    vecs[11] = '{3'd5, 3'd7, 3'd7, 5'd15, 33'h080000000, 33'h080000000, 33'h000000000, 33'h000000000, 5'h00, 2'd1, 33'h080000000, 33'h080000000, 33'h080000000, 3'd7};

    idleReq();
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset.req_ready", 33'(bus.req_ready), 33'd1);
    check("reset.resp_valid", 33'(bus.resp_valid), 33'd0);
    check("reset.pipe_validin", 33'(pipe_validin), 33'd0);
    check("reset.fflags", 33'(fflags), 33'd0);

    // Single-op vectors: mapping at issue, response exactly three cycles later.
    expF = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      bus.req_valid = 1'b1; bus.req_fn = vecs[i].fn; bus.req_rm = vecs[i].rm; frm = vecs[i].frm;
      bus.req_tag = vecs[i].tag; bus.req_a = vecs[i].a; bus.req_b = vecs[i].b; bus.req_c = vecs[i].c;
      stubOut = vecs[i].res; stubFlags = vecs[i].flg;
      #1;
      check($sformatf("v%0d.validin", i), 33'(pipe_validin), 33'd1);
      check($sformatf("v%0d.op", i), 33'(pipe_op), 33'(vecs[i].eOp));
      check($sformatf("v%0d.a", i), pipe_a, vecs[i].eA);
      check($sformatf("v%0d.b", i), pipe_b, vecs[i].eB);
      check($sformatf("v%0d.c", i), pipe_c, vecs[i].eC);
      check($sformatf("v%0d.rm", i), 33'(pipe_rm), 33'(vecs[i].eRm));
      @(negedge clock);
      idleReq();
      @(negedge clock);
      check($sformatf("v%0d.early_valid", i), 33'(bus.resp_valid), 33'd0);
      @(negedge clock);
      check($sformatf("v%0d.resp_valid", i), 33'(bus.resp_valid), 33'd1);
      check($sformatf("v%0d.resp_tag", i), 33'(bus.resp_tag), 33'(vecs[i].tag));
      check($sformatf("v%0d.resp_data", i), bus.resp_data, vecs[i].res);
      check($sformatf("v%0d.resp_flags", i), 33'(bus.resp_flags), 33'(vecs[i].flg));
      expF = expF | vecs[i].flg;
      @(negedge clock);
      check($sformatf("v%0d.drained", i), 33'(bus.resp_valid), 33'd0);
      check($sformatf("v%0d.fflags", i), 33'(fflags), 33'(expF));
    end

    // Clear without pop.
    @(negedge clock); fflags_clr = 1'b1;
    @(negedge clock); fflags_clr = 1'b0;
    check("clr.fflags", 33'(fflags), 33'd0);

    // Eight back-to-back ops with resp_ready high.
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      if (i >= 3 && i <= 10) begin
        check($sformatf("b2b%0d.valid", i), 33'(bus.resp_valid), 33'd1);
        check($sformatf("b2b%0d.tag", i), 33'(bus.resp_tag), 33'(i - 3));
        check($sformatf("b2b%0d.data", i), bus.resp_data, 33'h010000000 + 33'(i - 3));
      end else begin
        check($sformatf("b2b%0d.idle", i), 33'(bus.resp_valid), 33'd0);
      end
      if (i < 8) begin
        check($sformatf("b2b%0d.req_ready", i), 33'(bus.req_ready), 33'd1);
        driveOp(5'(i), 33'h010000000 + 33'(i), 5'h00);
      end else begin
        idleReq();
      end
    end

    // Backpressure: exactly DEPTH accepts, then drain in order.
    accepts = 0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("bp%0d.req_ready", i), 33'(bus.req_ready), (i < int'(DEPTH)) ? 33'd1 : 33'd0);
      if (bus.req_ready) accepts++;
      driveOp(5'(20 + i), 33'h020000000 + 33'(i), 5'h00);
    end
    @(negedge clock);
    idleReq();
    check("bp.accepts", 33'(accepts), 33'(DEPTH));
    check("bp.hold_valid", 33'(bus.resp_valid), 33'd1);
    check("bp.hold_tag", 33'(bus.resp_tag), 33'd20);
    @(negedge clock);
    check("bp.stable_tag", 33'(bus.resp_tag), 33'd20);
    check("bp.stable_data", bus.resp_data, 33'h020000000);
    bus.resp_ready = 1'b1;
    for (int j = 0; j < int'(DEPTH); j++) begin
      check($sformatf("drain%0d.valid", j), 33'(bus.resp_valid), 33'd1);
      check($sformatf("drain%0d.tag", j), 33'(bus.resp_tag), 33'(20 + j));
      check($sformatf("drain%0d.data", j), bus.resp_data, 33'h020000000 + 33'(j));
      @(negedge clock);
    end
    check("drain.empty", 33'(bus.resp_valid), 33'd0);
    check("drain.req_ready", 33'(bus.req_ready), 33'd1);

    // fflags_clr coinciding with the pop of an NX result keeps NX.
    @(negedge clock); driveOp(5'd3, 33'h0E0400000, 5'h10);
    @(negedge clock); idleReq();
    @(negedge clock);
    @(negedge clock);
    check("nv.valid", 33'(bus.resp_valid), 33'd1);
    @(negedge clock);
    check("nv.fflags", 33'(fflags), 33'h10);
    @(negedge clock); driveOp(5'd4, 33'h080000001, 5'h01);
    @(negedge clock); idleReq();
    @(negedge clock);
    @(negedge clock);
    check("nxclr.valid", 33'(bus.resp_valid), 33'd1);
    fflags_clr = 1'b1;
    @(negedge clock);
    fflags_clr = 1'b0;
    check("nxclr.fflags", 33'(fflags), 33'h01);

    // Reset with two ops in flight drops them.
    @(negedge clock); driveOp(5'd1, 33'h030000001, 5'h04);
    @(negedge clock); driveOp(5'd2, 33'h030000002, 5'h04);
    @(negedge clock); idleReq(); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    check("rst.fflags", 33'(fflags), 33'd0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst%0d.resp_valid", k), 33'(bus.resp_valid), 33'd0);
      check($sformatf("rst%0d.req_ready", k), 33'(bus.req_ready), 33'd1);
      @(negedge clock);
    end
    // Credits restored to zero: a full DEPTH of accepts again.
    accepts = 0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (bus.req_ready) accepts++;
      driveOp(5'(i), 33'h040000000, 5'h00);
      @(negedge clock);
    end
    idleReq();
    check("rst.accepts", 33'(accepts), 33'(DEPTH));
    check("rst.fflags_end", 33'(fflags), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
